// File: rtl/result_averager_pkg.sv
// Definitions shared between the dual-slope measurement FSM and the result averager.
package result_averager_pkg;

   localparam logic [1:0] AFE_IDLE        = 2'b00;
   localparam logic [1:0] AFE_AUTO_ZERO   = 2'b01;
   localparam logic [1:0] AFE_INTEGRATE   = 2'b10;
   localparam logic [1:0] AFE_DEINTEGRATE = 2'b11;

   localparam int unsigned DEFAULT_COUNT_W = 16;

endpackage

// File: rtl/sample_accumulator.sv
// Batch accumulator: sums 2^AVG_LOG2 signed samples taken on one range and strobes the
// floored average when the batch completes.
module sample_accumulator #(
   parameter int unsigned COUNT_W  = 16,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      clear_i,
   input  logic                      valid_i,
   input  logic signed [COUNT_W:0]   sample_i,
   input  logic [2:0]                range_i,
   output logic                      done_o,
   output logic signed [COUNT_W:0]   avg_o,
   output logic [2:0]                avg_range_o
);

   localparam int unsigned AW = COUNT_W + 1 + AVG_LOG2;
   localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned CW = AVG_LOG2 + 1;

   logic signed [AW-1:0] acc_q, acc_d;
   logic [NW-1:0]        n_q, n_d;
   logic [2:0]           rng_q, rng_d;

   logic                 restart;
   logic signed [AW-1:0] base;
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] shifted;
   logic [CW-1:0]        cnt;

   always_comb begin
      // An empty batch or a range change starts a fresh batch with this sample.
      restart = (n_q == '0) || (range_i != rng_q);
      base    = restart ? '0 : acc_q;
      sum     = base + AW'(sample_i);
      cnt     = restart ? CW'(1) : CW'(n_q) + CW'(1);
      shifted = sum >>> AVG_LOG2;

      done_o      = valid_i && !clear_i && cnt[AVG_LOG2];
      avg_o       = shifted[COUNT_W:0];
      avg_range_o = range_i;

      acc_d = acc_q;
      n_d   = n_q;
      rng_d = rng_q;
      if (clear_i) begin
         acc_d = '0;
         n_d   = '0;
      end else if (valid_i) begin
         rng_d = range_i;
         if (cnt[AVG_LOG2]) begin
            acc_d = '0;
            n_d   = '0;
         end else begin
            acc_d = sum;
            n_d   = NW'(cnt);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
         n_q   <= '0;
         rng_q <= '0;
      end else begin
         acc_q <= acc_d;
         n_q   <= n_d;
         rng_q <= rng_d;
      end
   end

endmodule

// File: rtl/result_averager.sv
// Averages signed dual-slope conversion results and hands them to the host over valid/ready.
module result_averager
   import result_averager_pkg::*;
#(
   parameter int unsigned COUNT_W  = DEFAULT_COUNT_W,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [1:0]           afe_sel_i,
   input  logic                 ref_sign_i,
   input  logic [2:0]           range_sel_i,
   input  logic                 range_error_i,
   input  logic                 done_i,
   input  logic [COUNT_W-1:0]   count_i,
   input  logic                 clear_i,
   output logic [COUNT_W:0]     result_o,
   output logic [2:0]           result_range_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic                 overrun_o,
   output logic                 error_o
);

   logic                   sign_q;
   logic signed [COUNT_W:0] mag;
   logic signed [COUNT_W:0] sample;
   logic                   discard;
   logic                   sample_valid;

   logic                   acc_done;
   logic signed [COUNT_W:0] acc_avg;
   logic [2:0]             acc_range;

   logic [COUNT_W:0] result_q, result_d;
   logic [2:0]       range_q, range_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             error_q, error_d;
   logic             accept;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sign_q <= 1'b0;
      end else if (afe_sel_i == AFE_INTEGRATE) begin
         sign_q <= ref_sign_i;
      end
   end

   always_comb begin
      mag          = {1'b0, count_i};
      sample       = sign_q ? -mag : mag;
      // An all-ones count means the deintegrate phase timed out.
      discard      = done_i && !clear_i && (range_error_i || (&count_i));
      sample_valid = done_i && !clear_i && !discard;
   end

   sample_accumulator #(
      .COUNT_W  (COUNT_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_sample_accumulator (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .clear_i     (clear_i || discard),
      .valid_i     (sample_valid),
      .sample_i    (sample),
      .range_i     (range_sel_i),
      .done_o      (acc_done),
      .avg_o       (acc_avg),
      .avg_range_o (acc_range)
   );

   always_comb begin
      accept    = valid_q && result_ready_i;
      result_d  = result_q;
      range_d   = range_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      error_d   = discard;
      if (clear_i) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
         end
         if (acc_done) begin
            result_d = acc_avg;
            range_d  = acc_range;
            valid_d  = 1'b1;
            if (valid_q && !result_ready_i) begin
               overrun_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         result_q  <= '0;
         range_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         result_q  <= result_d;
         range_q   <= range_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         error_q   <= error_d;
      end
   end

   assign result_o       = result_q;
   assign result_range_o = range_q;
   assign result_valid_o = valid_q;
   assign overrun_o      = overrun_q;
   assign error_o        = error_q;

endmodule

// File: tb/tb_result_averager.sv
// Directed, table-driven bench for result_averager (COUNT_W=16, AVG_LOG2=2).
module tb_result_averager;

   typedef struct {
      logic [1:0]  afe;
      logic        sgn;
      logic [2:0]  rng;
      logic        rerr;
      logic        done;
      logic [15:0] cnt;
      logic        clr;
      logic        rdy;
      logic        ev;
      logic [16:0] er;
      logic [2:0]  erg;
      logic        eov;
      logic        eerr;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  afe_sel;
   logic        ref_sign;
   logic [2:0]  range_sel;
   logic        range_error;
   logic        done;
   logic [15:0] count;
   logic        clear;
   logic [16:0] result;
   logic [2:0]  result_range;
   logic        result_valid;
   logic        result_ready;
   logic        overrun;
   logic        error;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   result_averager #(
      .COUNT_W  (16),
      .AVG_LOG2 (2)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .afe_sel_i      (afe_sel),
      .ref_sign_i     (ref_sign),
      .range_sel_i    (range_sel),
      .range_error_i  (range_error),
      .done_i         (done),
      .count_i        (count),
      .clear_i        (clear),
      .result_o       (result),
      .result_range_o (result_range),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
      .overrun_o      (overrun),
      .error_o        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] afe, input logic sgn, input logic [2:0] rng,
                               input logic rerr, input logic dn, input logic [15:0] cnt,
                               input logic clr, input logic rdy, input logic ev,
                               input logic [16:0] er, input logic [2:0] erg, input logic eov,
                               input logic eerr);
      vec_t v;
      v.afe = afe; v.sgn = sgn; v.rng = rng; v.rerr = rerr; v.done = dn; v.cnt = cnt;
      v.clr = clr; v.rdy = rdy; v.ev = ev; v.er = er; v.erg = erg; v.eov = eov; v.eerr = eerr;
      return v;
   endfunction

   // Done row on idle AFE, no error, no clear.
   function automatic vec_t dn(input logic [15:0] cnt, input logic [2:0] rng, input logic rdy,
                               input logic ev, input logic [16:0] er, input logic [2:0] erg,
                               input logic eov);
      return mk(2'b00, 1'b0, rng, 1'b0, 1'b1, cnt, 1'b0, rdy, ev, er, erg, eov, 1'b0);
   endfunction

   // Idle row with no done.
   function automatic vec_t idl(input logic [2:0] rng, input logic rdy, input logic ev,
                                input logic [16:0] er, input logic [2:0] erg, input logic eov);
      return mk(2'b00, 1'b0, rng, 1'b0, 1'b0, 16'd0, 1'b0, rdy, ev, er, erg, eov, 1'b0);
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      afe_sel     = v.afe;
      ref_sign    = v.sgn;
      range_sel   = v.rng;
      range_error = v.rerr;
      done        = v.done;
      count       = v.cnt;
      clear       = v.clr;
      result_ready = v.rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input vec_t v);
      logic [23:0] act;
      logic [23:0] exp;
      act = {result_valid, result, result_range, overrun, error};
      exp = {v.ev, v.er, v.erg, v.eov, v.eerr};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got valid=%b result=%h range=%0d ovr=%b err=%b, want valid=%b result=%h range=%0d ovr=%b err=%b",
                  name, result_valid, result, result_range, overrun, error,
                  v.ev, v.er, v.erg, v.eov, v.eerr);
      end
   endtask

   initial begin
      vec_t z;
      rst_n = 1'b0; afe_sel = 2'b00; ref_sign = 1'b0; range_sel = 3'd0; range_error = 1'b0;
      done = 1'b0; count = 16'd0; clear = 1'b0; result_ready = 1'b1;

      // Positive average 100..400 on range 3
      vecs.push_back(mk(2'b10, 1'b0, 3'd3, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 0, 17'd0, 3'd0, 0, 0));
      vecs.push_back(dn(16'd100, 3'd3, 1, 0, 17'd0, 3'd0, 0));
      vecs.push_back(dn(16'd200, 3'd3, 1, 0, 17'd0, 3'd0, 0));
      vecs.push_back(dn(16'd300, 3'd3, 1, 0, 17'd0, 3'd0, 0));
      vecs.push_back(dn(16'd400, 3'd3, 1, 1, 17'd250, 3'd3, 0));
      vecs.push_back(idl(3'd3, 1, 0, 17'd250, 3'd3, 0));
      // Negative sign: four counts of 1000
      vecs.push_back(mk(2'b10, 1'b1, 3'd3, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 0, 17'd250, 3'd3, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd1000, 3'd3, 1, 0, 17'd250, 3'd3, 0));
      vecs.push_back(dn(16'd1000, 3'd3, 1, 1, 17'h1FC18, 3'd3, 0));
      vecs.push_back(idl(3'd3, 1, 0, 17'h1FC18, 3'd3, 0));
      // Floor: -1,-1,-1,-2 -> -2
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd1, 3'd3, 1, 0, 17'h1FC18, 3'd3, 0));
      vecs.push_back(dn(16'd2, 3'd3, 1, 1, 17'h1FFFE, 3'd3, 0));
      // Floor: 1,1,1,2 -> 1
      vecs.push_back(mk(2'b10, 1'b0, 3'd3, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 0, 17'h1FFFE, 3'd3, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd1, 3'd3, 1, 0, 17'h1FFFE, 3'd3, 0));
      vecs.push_back(dn(16'd2, 3'd3, 1, 1, 17'd1, 3'd3, 0));
      vecs.push_back(idl(3'd3, 1, 0, 17'd1, 3'd3, 0));
      // Timeout discard mid-batch, then four fresh samples
      vecs.push_back(dn(16'd10, 3'd3, 1, 0, 17'd1, 3'd3, 0));
      vecs.push_back(dn(16'd20, 3'd3, 1, 0, 17'd1, 3'd3, 0));
      vecs.push_back(mk(2'b00, 1'b0, 3'd3, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 0, 17'd1, 3'd3, 0, 1));
      vecs.push_back(dn(16'd100, 3'd3, 1, 0, 17'd1, 3'd3, 0));
      vecs.push_back(dn(16'd200, 3'd3, 1, 0, 17'd1, 3'd3, 0));
      vecs.push_back(dn(16'd300, 3'd3, 1, 0, 17'd1, 3'd3, 0));
      vecs.push_back(dn(16'd400, 3'd3, 1, 1, 17'd250, 3'd3, 0));
      vecs.push_back(idl(3'd3, 1, 0, 17'd250, 3'd3, 0));
      // Range change after two samples
      vecs.push_back(dn(16'd500, 3'd3, 1, 0, 17'd250, 3'd3, 0));
      vecs.push_back(dn(16'd500, 3'd3, 1, 0, 17'd250, 3'd3, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd8, 3'd5, 1, 0, 17'd250, 3'd3, 0));
      vecs.push_back(dn(16'd16, 3'd5, 1, 1, 17'd10, 3'd5, 0));
      vecs.push_back(idl(3'd5, 1, 0, 17'd10, 3'd5, 0));
      // Range-error discard
      vecs.push_back(mk(2'b00, 1'b0, 3'd5, 1'b1, 1'b1, 16'd50, 1'b0, 1'b1, 0, 17'd10, 3'd5, 0, 1));
      vecs.push_back(idl(3'd5, 1, 0, 17'd10, 3'd5, 0));
      // Overrun: two completions with ready low
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd4, 3'd5, 0, 0, 17'd10, 3'd5, 0));
      vecs.push_back(dn(16'd4, 3'd5, 0, 1, 17'd4, 3'd5, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd8, 3'd5, 0, 1, 17'd4, 3'd5, 0));
      vecs.push_back(dn(16'd8, 3'd5, 0, 1, 17'd8, 3'd5, 1));
      vecs.push_back(idl(3'd5, 0, 1, 17'd8, 3'd5, 1));
      vecs.push_back(idl(3'd5, 1, 0, 17'd8, 3'd5, 0));
      // Completion on the accept edge
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd12, 3'd5, 0, 0, 17'd8, 3'd5, 0));
      vecs.push_back(dn(16'd12, 3'd5, 0, 1, 17'd12, 3'd5, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd20, 3'd5, 0, 1, 17'd12, 3'd5, 0));
      vecs.push_back(dn(16'd20, 3'd5, 1, 1, 17'd20, 3'd5, 0));
      vecs.push_back(idl(3'd5, 1, 0, 17'd20, 3'd5, 0));
      // clear_i with done_i drops the partial batch and the sample
      vecs.push_back(dn(16'd30, 3'd5, 1, 0, 17'd20, 3'd5, 0));
      vecs.push_back(dn(16'd30, 3'd5, 1, 0, 17'd20, 3'd5, 0));
      vecs.push_back(mk(2'b00, 1'b0, 3'd5, 1'b0, 1'b1, 16'd30, 1'b1, 1'b1, 0, 17'd20, 3'd5, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(dn(16'd40, 3'd5, 1, 0, 17'd20, 3'd5, 0));
      vecs.push_back(dn(16'd40, 3'd5, 1, 1, 17'd40, 3'd5, 0));
      vecs.push_back(idl(3'd5, 0, 1, 17'd40, 3'd5, 0));
      // clear_i drops a pending result
      vecs.push_back(mk(2'b00, 1'b0, 3'd5, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 0, 17'd40, 3'd5, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      z = idl(3'd0, 1, 0, 17'd0, 3'd0, 0);
      check("reset", z);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         check($sformatf("vec%0d", i), vecs[i]);
      end

      // Asynchronous reset mid-batch, then a fresh batch of four
      for (int i = 0; i < 2; i++) begin
         z = dn(16'd60, 3'd5, 1, 0, 17'd40, 3'd5, 0);
         apply(z);
         check($sformatf("prerst%0d", i), z);
      end
      @(negedge clk);
      done = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      z = idl(3'd0, 1, 0, 17'd0, 3'd0, 0);
      check("async_rst", z);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         z = dn(16'd60, 3'd5, 1, 0, 17'd0, 3'd0, 0);
         apply(z);
         check($sformatf("postrst%0d", i), z);
      end
      z = dn(16'd60, 3'd5, 1, 1, 17'd60, 3'd5, 0);
      apply(z);
      check("postrst3", z);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
